// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one divider among several requesters.
// Zero divisors are answered locally; a watchdog covers a silent divider.
module divider_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 11,
  parameter int TIMEOUT = 64
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic [NUM_REQ-1:0]              req_valid_in,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_dividend_in,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_divisor_in,
  output logic [NUM_REQ-1:0]              req_ready_out,
  output logic [NUM_REQ-1:0]              rsp_valid_out,
  output logic [WIDTH-1:0]                rsp_quotient_out,
  output logic [WIDTH-1:0]                rsp_remainder_out,
  output logic                            rsp_error_out,
  output logic                            busy_out,
  output logic [WIDTH-1:0]                div_dividend_out,
  output logic [WIDTH-1:0]                div_divisor_out,
  output logic                            div_valid_out,
  input  logic [WIDTH-1:0]                div_quotient_in,
  input  logic [WIDTH-1:0]                div_remainder_in,
  input  logic                            div_valid_in
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } state_e;

  state_e state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic err_q, err_d;
  logic busy_q, busy_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic div_valid_q, div_valid_d;

  logic found;
  logic [IW-1:0] pick;
  logic [IW-1:0] idx;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && req_valid_in[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    ready_d     = '0;
    rsp_valid_d = '0;
    quo_d       = quo_q;
    rem_d       = rem_q;
    err_d       = err_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    div_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          opa_d   = req_dividend_in[pick];
          opb_d   = req_divisor_in[pick];
          ready_d = NUM_REQ'(1) << pick;
          state_d = (req_divisor_in[pick] == '0) ? RESPOND : ISSUE;
        end
      end
      ISSUE: begin
        div_a_d     = opa_q;
        div_b_d     = opb_q;
        div_valid_d = 1'b1;
        cnt_d       = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        if (div_valid_in) begin
          quo_d       = div_quotient_in;
          rem_d       = div_remainder_in;
          err_d       = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          state_d     = RESPOND;
        end else if (cnt_q == LAST) begin
          quo_d       = '0;
          rem_d       = '0;
          err_d       = 1'b1;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          state_d     = RESPOND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESPOND: begin
        // only the zero-divisor path reaches here without a result
        if (opb_q == '0) begin
          quo_d       = '1;
          rem_d       = opa_q;
          err_d       = 1'b1;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
        end
        rr_ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      ready_q     <= '0;
      rsp_valid_q <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      div_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      div_valid_q <= div_valid_d;
    end
  end

  assign req_ready_out     = ready_q;
  assign rsp_valid_out     = rsp_valid_q;
  assign rsp_quotient_out  = quo_q;
  assign rsp_remainder_out = rem_q;
  assign rsp_error_out     = err_q;
  assign busy_out          = busy_q;
  assign div_dividend_out  = div_a_q;
  assign div_divisor_out   = div_b_q;
  assign div_valid_out     = div_valid_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter; the bench plays the shared divider.
// Expected results are hand values or the bench's own a/b arithmetic.
module tb_divider_arbiter;

  localparam int N  = 3;
  localparam int W  = 11;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req_valid;
  logic [N-1:0][W-1:0] req_a;
  logic [N-1:0][W-1:0] req_b;
  logic [N-1:0] ready;
  logic [N-1:0] rsp_valid;
  logic [W-1:0] rsp_q;
  logic [W-1:0] rsp_r;
  logic rsp_err;
  logic busy;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic div_v;
  logic [W-1:0] dq;
  logic [W-1:0] dr;
  logic dv;

  int n_checks = 0;
  int n_fail = 0;
  int div_pulses = 0;

  divider_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .req_valid_in      (req_valid),
    .req_dividend_in   (req_a),
    .req_divisor_in    (req_b),
    .req_ready_out     (ready),
    .rsp_valid_out     (rsp_valid),
    .rsp_quotient_out  (rsp_q),
    .rsp_remainder_out (rsp_r),
    .rsp_error_out     (rsp_err),
    .busy_out          (busy),
    .div_dividend_out  (div_a),
    .div_divisor_out   (div_b),
    .div_valid_out     (div_v),
    .div_quotient_in   (dq),
    .div_remainder_in  (dr),
    .div_valid_in      (dv)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (div_v) div_pulses++;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut;
    rst_n = 1'b0;
    req_valid = '0;
    dv = 1'b0;
    step;
    step;
    rst_n = 1'b1;
    step;
  endtask

  // raise a request, wait for its grant and for the divider issue
  task automatic start(input int who, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit hold);
    int n;
    req_a[who] = a;
    req_b[who] = b;
    req_valid[who] = 1'b1;
    n = 0;
    while (ready == '0 && n < 12) begin
      step;
      n++;
    end
    check("grant", 32'(ready), 32'(1 << who));
    if (!hold) req_valid[who] = 1'b0;
    n = 0;
    while (!div_v && n < 4) begin
      step;
      n++;
    end
    check("issue", 32'(div_v), 1);
    check("ready_pulse", 32'(ready), 0);
    check("div_a", 32'(div_a), 32'(a));
    check("div_b", 32'(div_b), 32'(b));
  endtask

  task automatic divide(input int who, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int lat,
                        input bit hold);
    start(who, a, b, hold);
    repeat (lat) step;
    dv = 1'b1;
    dq = a / b;
    dr = a % b;
    step;
    dv = 1'b0;
    check("rsp_valid", 32'(rsp_valid), 32'(1 << who));
    check("rsp_q", 32'(rsp_q), 32'(a / b));
    check("rsp_r", 32'(rsp_r), 32'(a % b));
    check("rsp_err", 32'(rsp_err), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    int n;
    logic [N-1:0] seen;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    dq = '0;
    dr = '0;
    dv = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_rsp", 32'(rsp_valid), 0);
    check("rst_divv", 32'(div_v), 0);
    reset_dut;

    // single requester 1: 300 / 19
    p0 = div_pulses;
    divide(1, 11'd300, 11'd19, 2, 1'b0);
    check("t1_q", 32'(rsp_q), 15);
    check("t1_r", 32'(rsp_r), 15);
    step;
    check("t1_rsp_pulse", 32'(rsp_valid), 0);
    step;
    check("t1_one_issue", 32'(div_pulses - p0), 1);
    check("t1_idle", 32'(busy), 0);

    // all three at once from reset: order 0,1,2,0
    reset_dut;
    req_a[0] = 11'd100;
    req_b[0] = 11'd7;
    req_a[1] = 11'd50;
    req_b[1] = 11'd5;
    req_a[2] = 11'd2000;
    req_b[2] = 11'd3;
    req_valid = 3'b111;
    divide(0, 11'd100, 11'd7, 0, 1'b1);
    check("rr0_q", 32'(rsp_q), 14);
    divide(1, 11'd50, 11'd5, 1, 1'b1);
    check("rr1_q", 32'(rsp_q), 10);
    divide(2, 11'd2000, 11'd3, 3, 1'b1);
    check("rr2_q", 32'(rsp_q), 666);
    divide(0, 11'd100, 11'd7, 0, 1'b1);
    req_valid = '0;
    step;
    step;

    // zero divisor on requester 2
    p0 = div_pulses;
    req_a[2] = 11'd77;
    req_b[2] = 11'd0;
    req_valid[2] = 1'b1;
    n = 0;
    while (ready == '0 && n < 12) begin
      step;
      n++;
    end
    check("z_grant", 32'(ready), 32'b100);
    check("z_early", 32'(rsp_valid), 0);
    req_valid[2] = 1'b0;
    step;
    check("z_rsp", 32'(rsp_valid), 32'b100);
    check("z_err", 32'(rsp_err), 1);
    check("z_q", 32'(rsp_q), 32'h7FF);
    check("z_r", 32'(rsp_r), 77);
    step;
    step;
    check("z_no_issue", 32'(div_pulses - p0), 0);

    // divider stays silent: watchdog response
    start(0, 11'd100, 11'd7, 1'b0);
    n = 0;
    while (rsp_valid == '0 && n < 200) begin
      step;
      n++;
    end
    check("to_cycles", 32'(n), TO);
    check("to_rsp", 32'(rsp_valid), 32'b001);
    check("to_err", 32'(rsp_err), 1);
    check("to_q", 32'(rsp_q), 0);
    check("to_r", 32'(rsp_r), 0);
    divide(1, 11'd1000, 11'd9, 1, 1'b0);
    check("after_to_q", 32'(rsp_q), 111);

    // asynchronous reset while waiting
    step;
    step;
    start(2, 11'd500, 11'd4, 1'b0);
    step;
    step;
    check("ar_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 0);
    check("ar_div_a", 32'(div_a), 0);
    check("ar_div_b", 32'(div_b), 0);
    check("ar_outs", 32'({ready, rsp_valid, div_v, rsp_err}), 0);
    step;
    rst_n = 1'b1;
    step;
    dv = 1'b1;
    dq = 11'd125;
    dr = 11'd0;
    seen = '0;
    step;
    dv = 1'b0;
    seen |= rsp_valid;
    repeat (3) begin
      step;
      seen |= rsp_valid;
    end
    check("ar_no_rsp", 32'(seen), 0);
    divide(2, 11'd500, 11'd4, 0, 1'b0);
    check("ar_next_q", 32'(rsp_q), 125);

    // result arrives on the timeout cycle
    step;
    step;
    start(1, 11'd999, 11'd10, 1'b0);
    repeat (TO - 1) step;
    check("co_early", 32'(rsp_valid), 0);
    dv = 1'b1;
    dq = 11'd99;
    dr = 11'd9;
    step;
    dv = 1'b0;
    check("co_rsp", 32'(rsp_valid), 32'b010);
    check("co_err", 32'(rsp_err), 0);
    check("co_q", 32'(rsp_q), 99);
    check("co_r", 32'(rsp_r), 9);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one `divider` instance among NUM_REQ requesters, e.g. `find_mod_size` and the grid sampler's pixel-pitch computations.
- Arbitrates round-robin, latches the winner's operands and issues one divide.
- Waits for the result under a watchdog, then returns quotient, remainder and error to the owning requester only.
- Short-circuits divide-by-zero so the shared divider never sees a zero divisor.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- WIDTH, 11, operand/result width; must match the divider's WIDTH.
- TIMEOUT, 64, cycles to wait for divider completion before an error response (≥ WIDTH+4).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- req_valid_in  input  NUM_REQ  per-requester request; operands held stable while high.
- req_dividend_in  input  [WIDTH-1:0] x NUM_REQ  per-requester dividend.
- req_divisor_in  input  [WIDTH-1:0] x NUM_REQ  per-requester divisor.
- req_ready_out  output  NUM_REQ  one-cycle accept pulse, one-hot.
- rsp_valid_out  output  NUM_REQ  one-cycle result pulse to owner, one-hot.
- rsp_quotient_out  output  WIDTH  result quotient (shared bus).
- rsp_remainder_out  output  WIDTH  result remainder (shared bus).
- rsp_error_out  output  1  divide-by-zero or timeout; qualified by rsp_valid_out.
- busy_out  output  1  high in every state except IDLE.
- div_dividend_out  output  WIDTH  to divider dividend_in.
- div_divisor_out  output  WIDTH  to divider divisor_in.
- div_valid_out  output  1  to divider data_valid_in.
- div_quotient_in  input  WIDTH  from divider quotient_out.
- div_remainder_in  input  WIDTH  from divider remainder_out.
- div_valid_in  input  1  from divider data_valid_out.

Behaviour:
- Reset (rst_n_in low, asynchronous): all outputs 0, state IDLE, rr_ptr=0, owner=0, timeout counter 0. Asserting reset mid-operation drops the transaction silently; no response is ever produced for it.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If any req_valid_in is set, select the first set bit searching from rr_ptr upward, mod NUM_REQ.
  - Latch the selected requester's dividend and divisor, set owner, and pulse req_ready_out[owner] in the next cycle.
  - If the latched divisor is 0: go to RESPOND with error=1, quotient all-ones, remainder = dividend.
  - Otherwise go to ISSUE.
  - div_valid_in is ignored in IDLE (stale or post-reset pulses).
- Requester rule: deassert req_valid_in, or present a new request, in the cycle after seeing req_ready_out. The arbiter samples requests only in IDLE, so there is no double accept.
- ISSUE: drive div_dividend_out/div_divisor_out from the latches, pulse div_valid_out for exactly 1 cycle, clear the timeout counter, go to WAIT. Operand outputs hold their values until the next issue.
- WAIT:
  - Counter increments each cycle.
  - On div_valid_in: latch quotient and remainder, error=0, go to RESPOND.
  - Else if counter == TIMEOUT-1: error=1, quotient=0, remainder=0, go to RESPOND.
  - div_valid_in arriving in the same cycle as the timeout: the result wins.
- RESPOND: rsp_valid_out[owner]=1 for 1 cycle with the data/error buses valid; rr_ptr <= (owner+1) mod NUM_REQ; go to IDLE.
- Data buses hold their last values outside RESPOND.
- Latency:
  - Accept pulse = request-seen cycle + 1.
  - div_valid_out = accept + 1.
  - rsp_valid_out = divider completion + 1.
  - Zero-divisor response = accept + 1.
- Fairness: a continuously requesting client is served at least once every NUM_REQ transactions.
- Simultaneous requests: only one is granted per transaction; the others stay pending and are never dropped.

Test Plan:
- Single requester 1, dividend 300, divisor 19 -> req_ready_out=3'b010, one div_valid_out pulse, rsp_valid_out=3'b010, quotient 15, remainder 15, error 0.
- All three requesting at once from reset -> grant order 0,1,2,0 with rr_ptr rotating; each rsp_valid_out one-hot to the correct owner with the correct quotient.
- Requester 2, divisor 0, dividend 77 -> div_valid_out never pulses; rsp_valid_out=3'b100, error 1, quotient 11'h7FF, remainder 77, two cycles after the request.
- Divider model withholds div_valid_in -> after TIMEOUT cycles in WAIT: rsp error 1, quotient 0; arbiter returns to IDLE and serves the next request normally.
- rst_n_in pulsed low during WAIT -> all outputs 0 immediately (asynchronous); a late div_valid_in in IDLE produces no response; the next request completes normally.
- div_valid_in coincident with the timeout cycle -> error 0 and the divider quotient is returned.
